// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory controller slice.
//   word_t      : 16-bit LC-3 machine word
//   mem_state_t : memory-access FSM states (IDLE, ACCESS, COMPLETE)
package lc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// Bundle of request, memory-bus, MDR and status signals around lc3_mem_ctrl.
//   master : the controller's view (drives req_ready, mem_*, mdr_*, done,
//            err_timeout, dbg_state)
//   slave  : the environment's view (control unit + memory model)
//
// Request handshake: a request transfers on a posedge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE (and never during reset);
// req_valid seen while req_ready is 0 is ignored, nothing is queued.
interface lc3_mem_ctrl_if #(
    parameter int WIDTH = 16
);
    import lc3_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             mem_en;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic             mdr_write_en;
    logic [WIDTH-1:0] mdr_data;
    logic             done;
    logic             err_timeout;
    mem_state_t       dbg_state;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
               mdr_write_en, mdr_data, done, err_timeout, dbg_state
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
               mdr_write_en, mdr_data, done, err_timeout, dbg_state
    );

endinterface

// File: rtl/lc3_mem_ctrl_reg.sv
// Generic load-enable register with asynchronous active-high clear.
//   clk, rst  : clock, async reset (q -> 0)
//   write_en  : load d on posedge
//   d, q      : data in / registered data out
module lc3_mem_ctrl_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           q <= '0;
        else if (write_en) q <= d;
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access controller. Accepts one request in IDLE, latches
// address/data/direction, strobes memory until mem_ack or a timeout, then
// pulses done (qualified by err_timeout) for one cycle in COMPLETE.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lc3_mem_ctrl_if.master (request, memory, MDR, status, debug)
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    lc3_mem_ctrl_if.master     bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             err_q;
    logic             accept;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             in_access;

    // State is already IDLE while rst is high; gating keeps ready low during reset.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign in_access     = (state == ACCESS);

    lc3_mem_ctrl_reg #(.WIDTH(WIDTH)) u_addr_reg (
        .clk(clk), .rst(rst), .write_en(accept), .d(bus.req_addr), .q(addr_q)
    );

    lc3_mem_ctrl_reg #(.WIDTH(WIDTH)) u_wdata_reg (
        .clk(clk), .rst(rst), .write_en(accept), .d(bus.req_wdata), .q(wdata_q)
    );

    lc3_mem_ctrl_reg #(.WIDTH(1)) u_we_reg (
        .clk(clk), .rst(rst), .write_en(accept), .d(bus.req_we), .q(we_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (accept) begin
                        cnt   <= '0;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Ack is tested first so an ack in the last permitted
                    // cycle completes normally instead of timing out.
                    if (bus.mem_ack) begin
                        state  <= COMPLETE;
                        done_q <= 1'b1;
                        err_q  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= COMPLETE;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                COMPLETE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_en      = in_access;
    assign bus.mem_we      = in_access && we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.dbg_state   = state;

    // The MDR captures on the same edge that ends ACCESS, so its enable must be
    // combinational with mem_ack; mdr_data is a straight pass-through.
    assign bus.mdr_write_en = in_access && bus.mem_ack && !we_q;
    assign bus.mdr_data     = bus.mem_rdata;

endmodule
